gaussian_filter_param: RTL and testbench

Parametrised 3x3 stencil filter for the raster pixel path. It is the next generation of the fixed 8-bit Gaussian stage and adds configurable pixel width and line length, a runtime mode (bypass / Gaussian / sharpen), frame-start resynchronisation, saturating arithmetic, a fixed-latency pipeline and an end-of-line marker. It sits between the capture/format stage and the downstream edge/threshold stages and consumes one pixel per `data_valid` beat.

---
 rtl/gauss_pkg.sv | 11 +
 rtl/line_buffer_2row.sv | 43 ++++
 rtl/gaussian_filter_param.sv | 167 ++++++++++++++++
 tb/tb_gaussian_filter_param.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared constants for the parametrised 3x3 stencil filter: mode codes,
// Gaussian scaling and the sharpen centre weight.
package gauss_pkg;
  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_GAUSS  = 2'd1;
  localparam logic [1:0] MODE_SHARP  = 2'd2;

  localparam int GAUSS_SHIFT = 4;
  localparam int GAUSS_RND   = 8;
  localparam int SHARP_CW    = 5;
endpackage

// File: rtl/line_buffer_2row.sv
// Two-row line store in one RAM word {row r-1, row r-2}. Reads are registered;
// the write-back of a beat is deferred one cycle so it can reuse the read data.
module line_buffer_2row #(
  parameter int DATA_W    = 8,
  parameter int MAX_WIDTH = 1024,
  parameter int ADDR_W    = $clog2(MAX_WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] rd_r1,
  output logic [DATA_W-1:0] rd_r2
);
  logic [2*DATA_W-1:0] mem [MAX_WIDTH];
  logic [2*DATA_W-1:0] rd_q;
  logic                wr_pend;
  logic [ADDR_W-1:0]   wr_idx;
  logic [DATA_W-1:0]   wr_din;

  // Consecutive beats always hit different columns, so the deferred write
  // never collides with a read that needs its result.
  always_ff @(posedge clk) begin
    if (we) rd_q <= mem[idx];
    if (wr_pend) mem[wr_idx] <= {wr_din, rd_q[2*DATA_W-1:DATA_W]};
  end

  always_ff @(posedge clk) begin
    if (we) begin
      wr_idx <= idx;
      wr_din <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_pend <= 1'b0;
    else     wr_pend <= we;
  end

  assign rd_r1 = rd_q[2*DATA_W-1:DATA_W];
  assign rd_r2 = rd_q[DATA_W-1:0];
endmodule

// File: rtl/gaussian_filter_param.sv
// 3x3 bypass/Gaussian/sharpen raster filter, fixed 3-cycle latency, no border output.
// Define GAUSS_ROUND_EN for round-half-up Gaussian scaling (default: truncate).
module gaussian_filter_param
  import gauss_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_WIDTH = 1024,
  parameter int CNT_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              sof,
  input  logic [CNT_W-1:0]  img_width,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              data_out_eol,
  output logic              cfg_err
);
  localparam int ADDR_W = $clog2(MAX_WIDTH);
  localparam int ACC_W  = DATA_W + 4;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_W) - 1);

  function automatic logic [DATA_W-1:0] gauss_scale(input logic [ACC_W-1:0] s);
    logic [ACC_W-1:0] t;
`ifdef GAUSS_ROUND_EN
    t = s + ACC_W'(GAUSS_RND);
`else
    t = s;
`endif
    return t[ACC_W-1:GAUSS_SHIFT];
  endfunction

  function automatic logic [DATA_W-1:0] sat_pix(input logic signed [ACC_W-1:0] s);
    if (s[ACC_W-1])       return '0;
    else if (s > PIX_MAX) return '1;
    else                  return s[DATA_W-1:0];
  endfunction

  logic [CNT_W-1:0]  col, width_q, col_eff, width_eff;
  logic [1:0]        rows, rows_eff, mode_q, mode_eff;
  logic              err_eff, last_col, win_ok;

  logic              beat_p0, vld_p0, eol_p0;
  logic [1:0]        mode_p0;
  logic [DATA_W-1:0] data_p0, lb_r1, lb_r2;

  logic              vld_p1, eol_p1;
  logic [1:0]        mode_p1;
  logic [DATA_W-1:0] win_p1 [3][3];

  logic              vld_p2, eol_p2;
  logic [1:0]        mode_p2;
  logic [DATA_W+1:0] corner_p2, edge_p2;
  logic [DATA_W-1:0] cen_p2;

  logic [ACC_W-1:0]        gsum;
  logic signed [ACC_W-1:0] ssum;
  logic [DATA_W-1:0]       result;

  // A sof beat behaves as column 0 of a fresh frame with its own width/mode.
  always_comb begin
    col_eff   = sof ? '0 : col;
    rows_eff  = sof ? 2'd0 : rows;
    width_eff = sof ? img_width : width_q;
    mode_eff  = sof ? mode : mode_q;
    err_eff   = sof ? (img_width < CNT_W'(3) || img_width > CNT_W'(MAX_WIDTH)) : cfg_err;
    last_col  = (col_eff == width_eff - CNT_W'(1));
    win_ok    = (rows_eff == 2'd2) && (col_eff >= CNT_W'(2)) && !err_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col            <= '0;
      rows           <= 2'd0;
      width_q        <= CNT_W'(MAX_WIDTH);
      mode_q         <= MODE_BYPASS;
      cfg_err        <= 1'b0;
      beat_p0        <= 1'b0;
      vld_p0         <= 1'b0;
      vld_p1         <= 1'b0;
      vld_p2         <= 1'b0;
      data_out_valid <= 1'b0;
    end else begin
      beat_p0        <= data_valid;
      vld_p0         <= data_valid && win_ok;
      vld_p1         <= vld_p0;
      vld_p2         <= vld_p1;
      data_out_valid <= vld_p2;
      if (data_valid) begin
        width_q <= width_eff;
        mode_q  <= mode_eff;
        cfg_err <= err_eff;
        col     <= last_col ? '0 : col_eff + CNT_W'(1);
        rows    <= (last_col && rows_eff != 2'd2) ? rows_eff + 2'd1 : rows_eff;
      end
    end
  end

  // S0: line-buffer access and input capture
  line_buffer_2row #(.DATA_W(DATA_W), .MAX_WIDTH(MAX_WIDTH), .ADDR_W(ADDR_W)) u_lb (
    .clk   (clk),
    .rst   (rst),
    .we    (data_valid),
    .idx   (col_eff[ADDR_W-1:0]),
    .din   (data_in),
    .rd_r1 (lb_r1),
    .rd_r2 (lb_r2)
  );

  always_ff @(posedge clk) begin
    if (data_valid) begin
      data_p0 <= data_in;
      eol_p0  <= last_col;
      mode_p0 <= mode_eff;
    end
  end

  // S1: window shift, rows top (r-2) to bottom (r), columns oldest to newest
  always_ff @(posedge clk) begin
    if (beat_p0) begin
      for (int r = 0; r < 3; r++) begin
        win_p1[r][0] <= win_p1[r][1];
        win_p1[r][1] <= win_p1[r][2];
      end
      win_p1[0][2] <= lb_r2;
      win_p1[1][2] <= lb_r1;
      win_p1[2][2] <= data_p0;
      eol_p1       <= eol_p0;
      mode_p1      <= mode_p0;
    end
  end

  // S2: partial sums
  always_ff @(posedge clk) begin
    corner_p2 <= {2'b00, win_p1[0][0]} + {2'b00, win_p1[0][2]}
               + {2'b00, win_p1[2][0]} + {2'b00, win_p1[2][2]};
    edge_p2   <= {2'b00, win_p1[0][1]} + {2'b00, win_p1[2][1]}
               + {2'b00, win_p1[1][0]} + {2'b00, win_p1[1][2]};
    cen_p2    <= win_p1[1][1];
    eol_p2    <= eol_p1;
    mode_p2   <= mode_p1;
  end

  // S3: combine, scale/clamp, output register
  always_comb begin
    gsum = ACC_W'(corner_p2) + (ACC_W'(edge_p2) << 1) + (ACC_W'(cen_p2) << 2);
    ssum = signed'(ACC_W'(cen_p2) * ACC_W'(SHARP_CW)) - signed'(ACC_W'(edge_p2));
    case (mode_p2)
      MODE_GAUSS: result = gauss_scale(gsum);
      MODE_SHARP: result = sat_pix(ssum);
      default:    result = cen_p2;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out     <= '0;
      data_out_eol <= 1'b0;
    end else begin
      if (vld_p2) data_out <= result;
      data_out_eol <= vld_p2 && eol_p2;
    end
  end
endmodule

// File: tb/tb_gaussian_filter_param.sv
// Randomised scoreboard bench for gaussian_filter_param: frame-level reference
// model feeds an expectation queue, a negedge monitor pops and compares.
module tb_gaussian_filter_param;
  localparam int DATA_W    = 8;
  localparam int MAX_WIDTH = 1024;
  localparam int CNT_W     = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              sof;
  logic [CNT_W-1:0]  img_width;
  logic [1:0]        mode;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              data_out_eol;
  logic              cfg_err;

  gaussian_filter_param #(.DATA_W(DATA_W), .MAX_WIDTH(MAX_WIDTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .sof            (sof),
    .img_width      (img_width),
    .mode           (mode),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_eol   (data_out_eol),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    bit eol;
    int due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   frm [0:4095];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int px(int W, int r, int c);
    return frm[r*W + c];
  endfunction

  // Output pixel centred at (r,c) of the frame currently in frm[].
  function automatic int ref_pix(int md, int W, int r, int c);
    int sum;
    sum = 0;
    if (md == 1) begin
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          sum += (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc)) * px(W, r+dr, c+dc);
`ifdef GAUSS_ROUND_EN
      return (sum + 8) / 16;
`else
      return sum / 16;
`endif
    end else if (md == 2) begin
      sum = 5*px(W, r, c) - px(W, r-1, c) - px(W, r+1, c) - px(W, r, c-1) - px(W, r, c+1);
      if (sum < 0)   return 0;
      if (sum > 255) return 255;
      return sum;
    end
    return px(W, r, c);
  endfunction

  always @(negedge clk) begin
    if (!rst && data_out_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got data_out=%0d eol=%0d at cycle %0d, expected no output",
                 data_out, data_out_eol, cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("out_data", 32'(data_out), mon_e.val);
        check("out_eol", 32'(data_out_eol), int'(mon_e.eol));
        check("out_latency_cycle", 32'(cyc), mon_e.due);
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    data_valid = 1'b0;
    sof        = 1'($urandom);
    data_in    = DATA_W'($urandom);
    img_width  = CNT_W'($urandom);
    mode       = 2'($urandom);
  endtask

  task automatic send_frame(input int W, input int H, input int md, input int gap_pct, input int nbeats);
    int r, c;
    bit ok;
    ok = (W >= 3 && W <= MAX_WIDTH);
    for (int i = 0; i < nbeats; i++) begin
      while (int'($urandom_range(99)) < gap_pct) idle();
      r = i / W;
      c = i % W;
      @(posedge clk); #1;
      data_valid = 1'b1;
      sof        = (i == 0);
      data_in    = DATA_W'(frm[i]);
      img_width  = (i == 0) ? CNT_W'(W) : CNT_W'($urandom);
      mode       = (i == 0) ? 2'(md) : 2'($urandom);
      if (ok && r >= 2 && c >= 2 && r < H)
        sbq.push_back('{val: ref_pix(md, W, r-1, c-1), eol: (c == W-1), due: cyc + 4});
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
    sof        = 1'b0;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 4096; i++) frm[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 4096; i++)
      case ($urandom_range(3))
        0:       frm[i] = 0;
        1:       frm[i] = 255;
        default: frm[i] = int'($urandom_range(255));
      endcase
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sbq.size() > 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(sbq.size()), 0);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 0);
    check({tag, "_valid"}, 32'(data_out_valid), 0);
    check({tag, "_eol"}, 32'(data_out_eol), 0);
    check({tag, "_cfg_err"}, 32'(cfg_err), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    sbq.delete();
    reset_check("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int W, H, md;
    rst = 1'b1; data_valid = 1'b0; sof = 1'b0; data_in = '0; img_width = '0; mode = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_check("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Flat frame
    fill_const(100);
    send_frame(4, 4, 1, 0, 16);
    drain();

    // Sharpen clamps
    fill_const(0); frm[4] = 200;
    send_frame(3, 3, 2, 0, 9);
    fill_const(100); frm[4] = 0;
    send_frame(3, 3, 2, 0, 9);
    drain();

    // Rounding: corner then centre
    fill_const(0); frm[0] = 8;
    send_frame(3, 3, 1, 0, 9);
    fill_const(0); frm[4] = 8;
    send_frame(3, 3, 1, 0, 9);
    drain();

    // Ramp, gapless then gapped
    for (int i = 0; i < 30; i++) frm[i] = (i * 37 + (i / 6) * 11) % 256;
    for (int m = 0; m < 3; m++) begin
      send_frame(6, 5, m, 0, 30);
      send_frame(6, 5, m, 40, 30);
    end
    drain();

    // Bad widths
    fill_rand();
    send_frame(2, 4, 1, 0, 8);
    check("cfg_err_w2", 32'(cfg_err), 1);
    send_frame(MAX_WIDTH + 1, 1, 1, 0, 5);
    check("cfg_err_wmax", 32'(cfg_err), 1);
    repeat (6) @(posedge clk);
    do_reset();
    send_frame(2, 4, 2, 0, 8);
    check("cfg_err_w2_again", 32'(cfg_err), 1);
    fill_const(50); frm[5] = 90;
    send_frame(4, 4, 1, 0, 16);
    check("cfg_err_cleared", 32'(cfg_err), 0);
    drain();

    // Mid-row sof: two in-flight outputs still emerge, then a fresh frame
    fill_rand();
    send_frame(5, 5, 1, 0, 14);
    fill_rand();
    send_frame(5, 4, 2, 20, 20);
    drain();

    // Reset mid-frame, then a fresh frame
    fill_rand();
    send_frame(5, 5, 1, 0, 13);
    do_reset();
    fill_rand();
    send_frame(5, 4, 1, 10, 20);
    drain();

    // Random frames, all modes including reserved
    for (int t = 0; t < 8; t++) begin
      W  = int'($urandom_range(3, 8));
      H  = int'($urandom_range(3, 6));
      md = int'($urandom_range(0, 3));
      fill_rand();
      send_frame(W, H, md, 30, W*H);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
